// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL lock driven memory/CPU reset sequencer
module pll_reset_seq #(
    parameter int STABLE_CYCLES = 1024,
    parameter int MEM_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked,
    input  logic       soft_reset,
    output logic       mem_reset,
    output logic       cpu_reset,
    output logic       ready,
    output logic       lock_lost,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        MEM_INIT  = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] MEM_LAST    = 16'(MEM_CYCLES - 1);

    logic        sync1;
    logic        locked_s;
    state_t      cur;
    logic [15:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= locked;
            locked_s <= sync1;
        end
    end

    assign state = cur;

    // Outputs are set alongside each state change so they are registered with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur       <= WAIT_LOCK;
            count     <= 16'd0;
            mem_reset <= 1'b1;
            cpu_reset <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            case (cur)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        cur   <= SETTLE;
                        count <= 16'd0;
                    end
                end
                SETTLE: begin
                    if (!locked_s) begin
                        cur       <= WAIT_LOCK;
                        count     <= 16'd0;
                        lock_lost <= 1'b1;
                    end else if (count == SETTLE_LAST) begin
                        cur       <= MEM_INIT;
                        count     <= 16'd0;
                        mem_reset <= 1'b0;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                MEM_INIT: begin
                    if (!locked_s) begin
                        cur       <= WAIT_LOCK;
                        count     <= 16'd0;
                        lock_lost <= 1'b1;
                        mem_reset <= 1'b1;
                        cpu_reset <= 1'b1;
                        ready     <= 1'b0;
                    end else if (soft_reset) begin
                        count <= 16'd0;
                    end else if (count == MEM_LAST) begin
                        cur       <= RUN;
                        count     <= 16'd0;
                        cpu_reset <= 1'b0;
                        ready     <= 1'b1;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        cur       <= WAIT_LOCK;
                        count     <= 16'd0;
                        lock_lost <= 1'b1;
                        mem_reset <= 1'b1;
                        cpu_reset <= 1'b1;
                        ready     <= 1'b0;
                    end else if (soft_reset) begin
                        cur       <= MEM_INIT;
                        count     <= 16'd0;
                        mem_reset <= 1'b0;
                        cpu_reset <= 1'b1;
                        ready     <= 1'b0;
                    end
                end
                default: begin
                    cur       <= WAIT_LOCK;
                    count     <= 16'd0;
                    mem_reset <= 1'b1;
                    cpu_reset <= 1'b1;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule
